// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a 1-entry holding buffer and
// redirect-pending tracking.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold the IF/ID output registers
//   redirect/_pc        taken branch or jump target from downstream
//   imem_addr/imem_req  instruction memory request (address is the PC)
//   imem_data/_ready    instruction memory response
//   instruction, PC_2   registered instruction and its PC+2 to decode
//   valid               instruction/PC_2 carry a real instruction
//   halted              a HALT word was fetched; fetch has stopped
//   err                 sticky misaligned-fetch error
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap fetches from an
// odd PC (err=1, fetch halts). Otherwise err is tied low and PC[0] goes
// to memory unchecked.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] instruction,
  output logic [15:0] PC_2,
  output logic        valid,
  output logic        halted,
  output logic        err
);

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] NOP_WORD = 16'h0800;
  localparam logic [XLEN-1:0] PC_STEP  = 16'd2;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus2;
  logic            hbuf_v;
  logic [XLEN-1:0] hbuf_instr;
  logic [XLEN-1:0] hbuf_pc2;
  logic            rp_v;
  logic [XLEN-1:0] rp_pc;
  logic            misalign;
  logic            req_int;
  logic            is_halt;

  assign pc_plus2 = pc + PC_STEP;
  assign is_halt  = (imem_data[15:11] == 5'b00000);

  // A misaligned PC is trapped only when a new request would be launched.
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = (state == S_RUN) && !hbuf_v && pc[0];
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  // No request while a buffered word is waiting to drain or fetch is stopped.
  assign req_int   = ((state == S_RUN) || (state == S_WAIT)) && !hbuf_v && !misalign;
  assign imem_req  = req_int && !rst;
  assign imem_addr = pc;

  // Fetch state machine, PC, holding buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= '0;
      instruction <= NOP_WORD;
      PC_2        <= '0;
      valid       <= 1'b0;
      halted      <= 1'b0;
      hbuf_v      <= 1'b0;
      hbuf_instr  <= '0;
      hbuf_pc2    <= '0;
      rp_v        <= 1'b0;
      rp_pc       <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      err         <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect beats stall: squash outputs and any buffered word.
      instruction <= NOP_WORD;
      valid       <= 1'b0;
      hbuf_v      <= 1'b0;
      halted      <= 1'b0;
      if ((state == S_WAIT) && !imem_ready) begin
        // Request still in flight: remember the target, keep the address.
        rp_v  <= 1'b1;
        rp_pc <= redirect_pc;
      end else begin
        // Any response in this cycle belongs to the wrong path and is dropped.
        pc    <= redirect_pc;
        state <= S_RUN;
        rp_v  <= 1'b0;
      end
    end else if (hbuf_v) begin
      // Drain the buffered word once decode can take it.
      if (!stall) begin
        instruction <= hbuf_instr;
        PC_2        <= hbuf_pc2;
        valid       <= 1'b1;
        hbuf_v      <= 1'b0;
      end
    end else begin
      case (state)
        S_RUN, S_WAIT: begin
          if (misalign) begin
`ifdef FETCH_ALIGN_CHECK_EN
            err <= 1'b1;
`endif
            halted <= 1'b1;
            state  <= S_HALT;
            if (!stall) begin
              instruction <= NOP_WORD;
              valid       <= 1'b0;
            end
          end else if (imem_ready) begin
            if (rp_v) begin
              // Late response for a squashed path: discard, jump to target.
              pc    <= rp_pc;
              rp_v  <= 1'b0;
              state <= S_RUN;
              if (!stall) begin
                instruction <= NOP_WORD;
                valid       <= 1'b0;
              end
            end else begin
              if (!stall) begin
                instruction <= imem_data;
                PC_2        <= pc_plus2;
                valid       <= 1'b1;
              end else begin
                hbuf_instr <= imem_data;
                hbuf_pc2   <= pc_plus2;
                hbuf_v     <= 1'b1;
              end
              if (is_halt) begin
                // HALT is delivered like any word; PC parks on it.
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                pc    <= pc_plus2;
                state <= S_RUN;
              end
            end
          end else begin
            state <= S_WAIT;
            if (!stall) begin
              instruction <= NOP_WORD;
              valid       <= 1'b0;
            end
          end
        end
        S_HALT: begin
          if (!stall) begin
            instruction <= NOP_WORD;
            valid       <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have these ports; clk comes first, then rst.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hazard unit holds the IF/ID outputs.
- redirect  in  1  a taken branch or jump resolved downstream.
- redirect_pc  in  16  target address, valid when redirect=1.
- imem_addr  out  16  instruction memory address.
- imem_req  out  1  a fetch request is active.
- imem_data  in  16  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory returns imem_data this cycle.
- instruction  out  16  registered instruction delivered to decode.
- PC_2  out  16  registered PC+2 of the delivered instruction.
- valid  out  1  instruction/PC_2 hold a real instruction.
- halted  out  1  a HALT was fetched; fetch has stopped.
- err  out  1  sticky fetch error.

Function
REQ-002 The block SHALL hold a 16-bit PC, a 1-entry holding buffer (hbuf_v, hbuf_instr, hbuf_pc2) and a redirect-pending register (rp_v, rp_pc).
REQ-003 The state machine SHALL have three states: RUN (free to request), WAIT (request outstanding, no response yet), HALT (fetch stopped).
REQ-004 imem_req SHALL be 1 only when the state is RUN or WAIT and hbuf_v=0.
- imem_addr SHALL equal PC.
REQ-005 While in WAIT, imem_addr SHALL stay stable until imem_ready=1, regardless of stall or redirect.
REQ-006 Accept: imem_req=1 and imem_ready=1 with no pending or new redirect.
- PC SHALL become PC+2 (16-bit wrap: 0xFFFE -> 0x0000).
- If stall=0: the output registers take imem_data, PC+2 and valid=1.
- If stall=1: the word and PC+2 go into hbuf instead, and hbuf_v=1.
REQ-007 When hbuf_v=1 and stall=0, the outputs SHALL load from hbuf with valid=1, hbuf_v SHALL clear, and no request is issued that cycle.
REQ-008 While stall=1 and there is no redirect, instruction, PC_2 and valid SHALL hold their values.
REQ-009 In RUN with imem_ready=0, the state SHALL go to WAIT.
- If stall=0, the outputs SHALL become a bubble: instruction=16'h0800 (NOP), valid=0.
REQ-010 redirect=1 SHALL take priority over stall in every case.
- The outputs become a bubble and hbuf_v clears.
- In RUN or HALT: PC<=redirect_pc and the state goes to RUN.
- In WAIT: rp_v<=1 and rp_pc<=redirect_pc.
REQ-011 A response that arrives while rp_v=1 SHALL be discarded.
- PC<=rp_pc, rp_v clears and the state goes to RUN.
- A later redirect while rp_v=1 SHALL overwrite rp_pc.
REQ-012 If an accepted word has imem_data[15:11]=5'b00000 (HALT), it SHALL be delivered normally, then the state goes to HALT, PC holds and halted=1.
REQ-013 In HALT, imem_req=0, and the outputs SHALL become a bubble after the HALT instruction is consumed (stall=0).
- Only redirect or rst leaves HALT; redirect also clears halted.
REQ-014 Fetch throughput SHALL be one instruction per cycle when imem_ready=1 continuously and stall=0.
- Latency from address to instruction output SHALL be 1 cycle.

Reset
REQ-015 When rst=1 at a rising edge, the block SHALL set: PC=0x0000, state=RUN, instruction=16'h0800, PC_2=0x0000, valid=0, halted=0, err=0, hbuf_v=0, rp_v=0.
REQ-016 During rst=1, imem_req SHALL be 0.
- A response arriving in the same cycle as reset SHALL be dropped.
- Reset mid-WAIT SHALL abandon the outstanding request.

Configuration
REQ-017 Macro FETCH_ALIGN_CHECK_EN, when defined:
- A request attempt with PC[0]=1 SHALL raise imem_req=0 instead.
- err SHALL go to 1 (sticky until rst), and the state SHALL go to HALT with halted=1.
- redirect does not clear err.
REQ-018 When FETCH_ALIGN_CHECK_EN is undefined, err SHALL be tied to 0 and PC[0] SHALL be passed to memory unchecked.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Reset, then imem_ready=1 continuously with words 0x4001, 0x4002, 0x4003 -> outputs 0x4001/PC_2=0x0002, 0x4002/0x0004, 0x4003/0x0006 on consecutive cycles, valid=1.
- imem_ready low for 3 cycles at PC=0x0010 -> imem_addr holds 0x0010, valid=0 with 0x0800 for 3 cycles, then the word is delivered.
- stall=1 for 2 cycles while a response arrives -> outputs hold, the word is held in hbuf, and after stall drops it is delivered with no lost or duplicate instruction.
- redirect to 0x0100 during WAIT at PC=0x0020 -> the late response is discarded, the next imem_addr is 0x0100, and the first valid output has PC_2=0x0102.
- HALT word 0x0000 at PC=0x0008 -> it is delivered with PC_2=0x000A, halted=1 and imem_req=0 afterwards, and rst returns PC to 0x0000.
- With FETCH_ALIGN_CHECK_EN defined, redirect to 0x0101 -> err=1, halted=1, and no request is issued.
